sensor_conditioner: RTL and testbench
=====================================

SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 Parameter DB_CYCLES, default 4, cycles a synchronized raw level must stay stable before the debounced output follows; legal range 1..255.
REQ-002 Parameter STUCK_CYCLES, default 600, consecutive cycles of debounced assertion after which a channel is flagged stuck; legal range 2..65535.
REQ-003 clk  input  1  single system clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 raw_a  input  1  asynchronous outer beam sensor, unconditioned.
REQ-006 raw_b  input  1  asynchronous inner beam sensor, unconditioned.
REQ-007 clr_fault  input  1  synchronous one-cycle request to clear both fault flags.
REQ-008 sensor_a  output  1  debounced active-high outer sensor, drives the counter's sensor_a.
REQ-009 sensor_b  output  1  debounced active-high inner sensor, drives the counter's sensor_b.
REQ-010 fault_a  output  1  sticky stuck flag for channel A.
REQ-011 fault_b  output  1  sticky stuck flag for channel B.

Function
REQ-012 Each channel SHALL pass its raw input through a two-flop synchronizer; only the second flop output (sync) feeds later logic.
REQ-013 Each rising edge: if sync equals the debounced output, the debounce counter SHALL clear to 0.
REQ-014 If sync differs and counter equals DB_CYCLES-1, the debounced output SHALL take sync and the counter SHALL clear; otherwise the counter SHALL increment.
REQ-015 A raw change held stable SHALL appear on sensor_x exactly DB_CYCLES+2 rising edges after the first edge that samples it.
REQ-016 A synchronized pulse or glitch shorter than DB_CYCLES cycles SHALL never reach sensor_x; any return to the current output level restarts the count.
REQ-017 Channels SHALL be fully independent; simultaneous changes on A and B SHALL each follow REQ-015 with no cross-interaction.
REQ-018 A stuck counter per channel SHALL increment each cycle sensor_x is 1, clear when sensor_x is 0, and saturate at STUCK_CYCLES.
REQ-019 fault_x SHALL set on the edge the stuck counter reaches STUCK_CYCLES and remain set until reset or clr_fault.
REQ-020 clr_fault SHALL clear both fault flags and both stuck counters on that edge, with priority over a same-cycle set; if sensor_x is still 1, counting resumes on the next edge.
REQ-021 Fault flags SHALL NOT gate or modify sensor_x.

Reset
REQ-022 With reset high at an edge, synchronizer flops, debounce counters, stuck counters, sensor_a, sensor_b, fault_a, fault_b SHALL all go to 0 (deasserted, post-polarity).
REQ-023 Reset asserted mid-debounce or mid-stuck-count SHALL abandon the count; after release a held raw level requires the full DB_CYCLES+2 latency again.
REQ-024 Reset SHALL override clr_fault and all other activity.

Configuration
REQ-025 Macro SENSOR_ACTIVE_LOW_EN defined: raw_a/raw_b SHALL be inverted before the first synchronizer flop (raw 0 = beam blocked); outputs stay active-high.
REQ-026 Macro SENSOR_ACTIVE_LOW_EN undefined: raw_a/raw_b SHALL be treated as active-high with no inversion.

Structure
REQ-027 Defaults for DB_CYCLES and STUCK_CYCLES SHALL live in the shared parking-lot package/include, used by this block and the top level.
REQ-028 Counter widths SHALL be derived from the parameters, not hard-coded.
REQ-029 One sub-module, sensor_debounce (synchronizer, debounce, stuck detector for a single channel), SHALL be instantiated twice.

Verification (bench uses DB_CYCLES=4, STUCK_CYCLES=16, macro undefined unless stated)
REQ-030 Reset 2 cycles, raw_a 0->1 held -> sensor_a rises exactly 6 edges after first sampling edge; sensor_b stays 0.
REQ-031 raw_b high for 3 cycles then low -> sensor_b stays 0 throughout; raw_b high 4 cycles -> sensor_b pulses high for 4 cycles, delayed 6 edges.
REQ-032 Full car sequence a=1,b=0 / 1,1 / 0,1 / 0,0, each held 10 cycles -> sensor_a/sensor_b reproduce the sequence delayed 6 edges, no extra transitions.
REQ-033 raw_a held high 30 cycles -> fault_a sets 16 edges after sensor_a rises, stays set after raw_a drops; clr_fault pulse -> fault_a 0 next edge.
REQ-034 raw_a high, assert reset after 3 cycles for 1 cycle, release -> sensor_a 0 during reset, rises 6 edges after release.
REQ-035 SENSOR_ACTIVE_LOW_EN defined, raw_a=raw_b=1 idle then raw_a 1->0 -> sensor_a rises after 6 edges, sensor_b stays 0.

Source files
------------

// File: rtl/sensor_conditioner_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sensor_conditioner_pkg : shared defaults and width helper for beam sensors
// Revision 1.0
// ---------------------------------------------------------------------------
package sensor_conditioner_pkg;

   localparam int DB_CYCLES_DEF    = 4;
   localparam int STUCK_CYCLES_DEF = 600;

   // Counter width able to hold values 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sensor_conditioner_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sensor_debounce : one channel - 2-flop synchronizer, debounce, stuck detect
// Revision 1.0
// ---------------------------------------------------------------------------
module sensor_debounce
   import sensor_conditioner_pkg::*;
#(
   parameter int DB_CYCLES    = DB_CYCLES_DEF,
   parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   input  logic clr_fault,
   output logic sensor,
   output logic fault
);

   localparam int DB_W = cnt_width(DB_CYCLES);
   localparam int ST_W = cnt_width(STUCK_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DB_CYCLES - 1);
   localparam logic [ST_W-1:0] ST_MAX   = ST_W'(STUCK_CYCLES);
   localparam logic [ST_W-1:0] ST_PRE   = ST_W'(STUCK_CYCLES - 1);

   logic            sync_meta;
   logic            sync;
   logic [DB_W-1:0] db_cnt;
   logic [ST_W-1:0] stuck_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_meta <= 1'b0;
         sync      <= 1'b0;
      end else begin
         sync_meta <= raw;
         sync      <= sync_meta;
      end
   end

   // Any sample matching the current output restarts the stability count.
   always_ff @(posedge clk) begin
      if (reset) begin
         db_cnt <= '0;
         sensor <= 1'b0;
      end else if (sync == sensor) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
         db_cnt <= '0;
         sensor <= sync;
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || clr_fault) begin
         stuck_cnt <= '0;
         fault     <= 1'b0;
      end else if (!sensor) begin
         stuck_cnt <= '0;
      end else if (stuck_cnt != ST_MAX) begin
         stuck_cnt <= stuck_cnt + 1'b1;
         if (stuck_cnt == ST_PRE) begin
            fault <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/sensor_conditioner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sensor_conditioner : debounced A/B beam sensors with sticky stuck flags.
// Optional macro SENSOR_ACTIVE_LOW_EN inverts raw inputs. Revision 1.0
// ---------------------------------------------------------------------------
module sensor_conditioner
   import sensor_conditioner_pkg::*;
#(
   parameter int DB_CYCLES    = DB_CYCLES_DEF,
   parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_a,
   input  logic raw_b,
   input  logic clr_fault,
   output logic sensor_a,
   output logic sensor_b,
   output logic fault_a,
   output logic fault_b
);

   logic raw_a_in;
   logic raw_b_in;

`ifdef SENSOR_ACTIVE_LOW_EN
   assign raw_a_in = ~raw_a;
   assign raw_b_in = ~raw_b;
`else
   assign raw_a_in = raw_a;
   assign raw_b_in = raw_b;
`endif

   sensor_debounce #(
      .DB_CYCLES    (DB_CYCLES),
      .STUCK_CYCLES (STUCK_CYCLES)
   ) u_deb_a (
      .clk       (clk),
      .reset     (reset),
      .raw       (raw_a_in),
      .clr_fault (clr_fault),
      .sensor    (sensor_a),
      .fault     (fault_a)
   );

   sensor_debounce #(
      .DB_CYCLES    (DB_CYCLES),
      .STUCK_CYCLES (STUCK_CYCLES)
   ) u_deb_b (
      .clk       (clk),
      .reset     (reset),
      .raw       (raw_b_in),
      .clr_fault (clr_fault),
      .sensor    (sensor_b),
      .fault     (fault_b)
   );

endmodule
`default_nettype wire

// File: tb/tb_sensor_conditioner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sensor_conditioner : scoreboard bench with a window-based reference model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_sensor_conditioner;

   localparam int DB = 4;
   localparam int ST = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic raw_a = 1'b0;
   logic raw_b = 1'b0;
   logic clr_fault = 1'b0;
   logic sensor_a, sensor_b, fault_a, fault_b;

   int errors = 0;
   int checks = 0;

   logic [3:0] exp_q[$];

   always #5 clk = ~clk;

   sensor_conditioner #(
      .DB_CYCLES    (DB),
      .STUCK_CYCLES (ST)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .raw_a     (raw_a),
      .raw_b     (raw_b),
      .clr_fault (clr_fault),
      .sensor_a  (sensor_a),
      .sensor_b  (sensor_b),
      .fault_a   (fault_a),
      .fault_b   (fault_b)
   );

   // Reference model: a channel output flips once the last DB synchronized
   // samples all disagree with it; stuck time is a saturating run length.
   bit p1[2], p2[2], deb[2], flt[2];
   bit hist[2][DB];
   int hlen[2];
   int scnt[2];

   task automatic model_step();
      bit [1:0] r;
      r = {raw_b, raw_a};
`ifdef SENSOR_ACTIVE_LOW_EN
      r = ~r;
`endif
      if (reset) begin
         for (int c = 0; c < 2; c++) begin
            p1[c] = 0; p2[c] = 0; deb[c] = 0; flt[c] = 0;
            hlen[c] = 0; scnt[c] = 0;
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            bit old_sync, old_deb, all_diff;
            old_sync = p2[c];
            p2[c] = p1[c];
            p1[c] = r[c];
            for (int i = DB - 1; i > 0; i--) hist[c][i] = hist[c][i-1];
            hist[c][0] = old_sync;
            if (hlen[c] < DB) hlen[c]++;
            old_deb = deb[c];
            all_diff = (hlen[c] == DB);
            for (int i = 0; i < DB; i++) if (hist[c][i] == old_deb) all_diff = 0;
            if (all_diff) deb[c] = ~old_deb;
            if (clr_fault) begin
               scnt[c] = 0;
               flt[c] = 0;
            end else if (old_deb) begin
               if (scnt[c] < ST) begin
                  scnt[c]++;
                  if (scnt[c] == ST) flt[c] = 1;
               end
            end else begin
               scnt[c] = 0;
            end
         end
      end
      exp_q.push_back({flt[1], flt[0], deb[1], deb[0]});
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      logic [3:0] exp_v;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         checks++;
         if ({fault_b, fault_a, sensor_b, sensor_a} !== exp_v) begin
            errors++;
            $display("FAIL outputs t=%0t got fb,fa,sb,sa=%b required=%b",
                     $time, {fault_b, fault_a, sensor_b, sensor_a}, exp_v);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_ab(input logic a, input logic b, input int n);
      raw_a = a;
      raw_b = b;
      cyc(n);
   endtask

   initial begin
      int n;
      int hold;
      @(negedge clk);
      cyc(2);
      reset = 1'b0;
      cyc(3);

      // Latency of a held rise, measured from the first sampling edge.
      raw_a = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         n++;
         #1;
      end while (!sensor_a && n < 20);
      checks++;
      if (n != DB + 2) begin
         errors++;
         $display("FAIL rise_latency got=%0d edges required=%0d", n, DB + 2);
      end
      @(negedge clk);
      raw_a = 1'b0;
      cyc(12);

      // Short and minimal pulses on B.
      set_ab(0, 1, 3);
      set_ab(0, 0, 10);
      set_ab(0, 1, 4);
      set_ab(0, 0, 12);

      // Car passage sequence.
      set_ab(1, 0, 10);
      set_ab(1, 1, 10);
      set_ab(0, 1, 10);
      set_ab(0, 0, 12);

      // Stuck detection and clear.
      set_ab(1, 0, 30);
      set_ab(0, 0, 10);
      clr_fault = 1'b1;
      cyc(1);
      clr_fault = 1'b0;
      cyc(5);

      // Reset in the middle of a debounce.
      set_ab(1, 0, 3);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      cyc(10);
      set_ab(0, 0, 10);

      // Randomized segments, occasionally long enough to trip the stuck flag.
      repeat (70) begin
         raw_a = 1'($urandom_range(0, 1));
         raw_b = 1'($urandom_range(0, 1));
         hold = ($urandom_range(0, 5) == 0) ? $urandom_range(17, 30) : $urandom_range(1, 7);
         for (int i = 0; i < hold; i++) begin
            clr_fault = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 119) == 0);
            cyc(1);
         end
      end
      clr_fault = 1'b0;
      reset = 1'b0;
      cyc(3);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d pending required=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
